// File: rtl/setassoc_cache_ctrl.sv
// Set-associative write-through / no-write-allocate cache controller, round-robin replacement.
// Optional CACHE_EARLY_RESTART_EN: critical-word-first refill with early CPU acknowledge.
module setassoc_cache_ctrl #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cpu2cc,
  input  logic [ADR_WIDTH-1:0]  adr_cpu2cc,
  input  logic [DATA_WIDTH-1:0] dat_cpu2cc,
  input  logic                  rdwr_cpu2cc,
  output logic                  ack_cc2cpu,
  output logic [DATA_WIDTH-1:0] dat_cc2cpu,
  output logic                  req_cc2mem,
  output logic [ADR_WIDTH-1:0]  adr_cc2mem,
  output logic [DATA_WIDTH-1:0] dat_cc2mem,
  output logic                  rdwr_cc2mem,
  input  logic                  ack_mem2cc,
  input  logic [DATA_WIDTH-1:0] dat_mem2cc
);
  localparam int OFFW = $clog2(DATA_WIDTH/8);
  localparam int WRDW = $clog2(WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int WAW  = ADR_WIDTH - OFFW;
  localparam int TAGW = WAW - IDXW - WRDW;
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;
`ifdef CACHE_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, REFILL, MEMWR, HOLD} state_t;

  state_t                state;
  logic [WAW-1:0]        a_wa;
  logic [DATA_WIDTH-1:0] a_dat;
  logic                  a_wr;
  logic                  drop;
  logic [WRDW-1:0]       cnt;
  logic [WAYW-1:0]       vic_r;
  logic [DATA_WIDTH-1:0] rdata;

  logic [WAYS-1:0]       valid    [SETS];
  logic [WAYW-1:0]       rr       [SETS];
  logic [TAGW-1:0]       tag_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][WORDS];

  logic [TAGW-1:0]       a_tag;
  logic [IDXW-1:0]       a_idx;
  logic [WRDW-1:0]       a_word;
  logic [WAW-WRDW-1:0]   a_line;
  logic [WRDW-1:0]       first_w, beat_w;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WAYW-1:0]       hit_way, vic_way;
  logic                  unused_adr;

  assign unused_adr = ^adr_cpu2cc;
  assign a_tag  = a_wa[WAW-1 -: TAGW];
  assign a_idx  = a_wa[WRDW +: IDXW];
  assign a_word = a_wa[WRDW-1:0];
  assign a_line = a_wa[WAW-1:WRDW];
  assign first_w = EARLY ? a_word : '0;
  assign beat_w  = first_w + cnt;

  function automatic logic [ADR_WIDTH-1:0] mk_adr(input logic [WAW-WRDW-1:0] line,
                                                  input logic [WRDW-1:0] w);
    logic [ADR_WIDTH-1:0] r;
    r = '0;
    r[ADR_WIDTH-1:OFFW] = {line, w};
    return r;
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = valid[a_idx][w] && (tag_mem[w][a_idx] == a_tag);
  end
  assign hit = |hit_vec;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit_way = '0;
    vic_way = rr[a_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w])        hit_way = WAYW'(w);
      if (!valid[a_idx][w])  vic_way = WAYW'(w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ack_cc2cpu  <= 1'b0;
      dat_cc2cpu  <= '0;
      req_cc2mem  <= 1'b0;
      adr_cc2mem  <= '0;
      dat_cc2mem  <= '0;
      rdwr_cc2mem <= 1'b0;
      a_wa        <= '0;
      a_dat       <= '0;
      a_wr        <= 1'b0;
      drop        <= 1'b0;
      cnt         <= '0;
      vic_r       <= '0;
      rdata       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      ack_cc2cpu <= 1'b0;
      if ((state == REFILL || state == MEMWR) && !req_cpu2cc) drop <= 1'b1;
      case (state)
        IDLE: if (req_cpu2cc) begin
          a_wa  <= adr_cpu2cc[ADR_WIDTH-1:OFFW];
          a_dat <= dat_cpu2cc;
          a_wr  <= rdwr_cpu2cc;
          drop  <= 1'b0;
          state <= LOOKUP;
        end
        LOOKUP: begin
          if (a_wr) begin
            req_cc2mem  <= 1'b1;
            rdwr_cc2mem <= 1'b1;
            adr_cc2mem  <= mk_adr(a_line, a_word);
            dat_cc2mem  <= a_dat;
            state       <= MEMWR;
          end else if (hit) begin
            rdata <= data_mem[hit_way][a_idx][a_word];
            state <= RESP;
          end else begin
            // Victim is invalidated up front so a partial refill never looks valid.
            vic_r                 <= vic_way;
            valid[a_idx][vic_way] <= 1'b0;
            if (&valid[a_idx])
              rr[a_idx] <= (rr[a_idx] == WAYW'(WAYS-1)) ? '0 : rr[a_idx] + 1'b1;
            cnt         <= '0;
            req_cc2mem  <= 1'b1;
            rdwr_cc2mem <= 1'b0;
            adr_cc2mem  <= mk_adr(a_line, first_w);
            state       <= REFILL;
          end
        end
        REFILL: if (ack_mem2cc) begin
          cnt        <= cnt + 1'b1;
          adr_cc2mem <= mk_adr(a_line, beat_w + 1'b1);
          if (beat_w == a_word) rdata <= dat_mem2cc;
          if (EARLY && cnt == '0 && req_cpu2cc && !drop) begin
            ack_cc2cpu <= 1'b1;
            dat_cc2cpu <= dat_mem2cc;
          end
          if (cnt == WRDW'(WORDS-1)) begin
            req_cc2mem          <= 1'b0;
            valid[a_idx][vic_r] <= 1'b1;
            state               <= EARLY ? HOLD : RESP;
          end
        end
        MEMWR: if (ack_mem2cc) begin
          req_cc2mem  <= 1'b0;
          rdwr_cc2mem <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (!drop) begin
            ack_cc2cpu <= 1'b1;
            if (!a_wr) dat_cc2cpu <= rdata;
          end
          state <= HOLD;
        end
        HOLD: if (!req_cpu2cc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && a_wr && hit) data_mem[hit_way][a_idx][a_word] <= a_dat;
    if (state == LOOKUP && !a_wr && !hit) tag_mem[vic_way][a_idx] <= a_tag;
    if (state == REFILL && ack_mem2cc) data_mem[vic_r][a_idx][beat_w] <= dat_mem2cc;
  end
endmodule

// File: tb/tb_setassoc_cache_ctrl.sv
// Directed bench for setassoc_cache_ctrl (4 ways, 64 sets, 4 words) with a word-echo memory model.
module tb_setassoc_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_cpu2cc, rdwr_cpu2cc;
  logic [31:0] adr_cpu2cc, dat_cpu2cc;
  logic        ack_cc2cpu;
  logic [31:0] dat_cc2cpu;
  logic        req_cc2mem, rdwr_cc2mem;
  logic [31:0] adr_cc2mem, dat_cc2mem;
  logic        ack_mem2cc;
  logic [31:0] dat_mem2cc;

  int          n_chk = 0, n_err = 0;
  int          beats = 0;
  logic [31:0] b_adr [16];
  logic        b_wr  [16];
  logic [31:0] b_dat [16];

`ifdef CACHE_EARLY_RESTART_EN
  localparam int MISS_LAT = 2;
  localparam logic [7:0] ORD = 8'b01_00_11_10;  // words 2,3,0,1 (LSB first)
`else
  localparam int MISS_LAT = 9;
  localparam logic [7:0] ORD = 8'b11_10_01_00;  // words 0,1,2,3
`endif

  setassoc_cache_ctrl #(.ADR_WIDTH(32), .DATA_WIDTH(32), .WAYS(4), .SETS(64), .WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_cpu2cc(req_cpu2cc), .adr_cpu2cc(adr_cpu2cc), .dat_cpu2cc(dat_cpu2cc),
    .rdwr_cpu2cc(rdwr_cpu2cc), .ack_cc2cpu(ack_cc2cpu), .dat_cc2cpu(dat_cc2cpu),
    .req_cc2mem(req_cc2mem), .adr_cc2mem(adr_cc2mem), .dat_cc2mem(dat_cc2mem),
    .rdwr_cc2mem(rdwr_cc2mem), .ack_mem2cc(ack_mem2cc), .dat_mem2cc(dat_mem2cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: one-cycle ack pulses with a gap; data = 0x100 + word index of the address.
  initial begin
    ack_mem2cc = 1'b0;
    dat_mem2cc = '0;
    forever begin
      @(negedge clk);
      if (rst && req_cc2mem && !ack_mem2cc) begin
        if (beats < 16) begin
          b_adr[beats] = adr_cc2mem;
          b_wr[beats]  = rdwr_cc2mem;
          b_dat[beats] = dat_cc2mem;
        end
        beats++;
        dat_mem2cc = 32'h100 + {30'h0, adr_cc2mem[3:2]};
        ack_mem2cc = 1'b1;
      end else begin
        ack_mem2cc = 1'b0;
      end
    end
  end

  // lat counts rising edges after the sampling edge (edge 0) until ack is seen.
  task automatic cpu_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input int abort,
                        output logic [31:0] rd, output int lat, output int nack);
    int cyc, tail;
    cyc = 0; tail = 0; lat = -1; nack = 0; rd = '0;
    beats = 0;
    @(negedge clk);
    adr_cpu2cc = a; dat_cpu2cc = d; rdwr_cpu2cc = wr; req_cpu2cc = 1'b1;
    while (cyc < 100 && tail < 3) begin
      @(posedge clk); #1;
      if (ack_cc2cpu) begin
        nack++;
        if (lat < 0) begin lat = cyc; rd = dat_cc2cpu; end
      end
      cyc++;
      @(negedge clk);
      adr_cpu2cc = ~a; dat_cpu2cc = ~d;
      if (req_cpu2cc && ((lat >= 0 && cyc >= hold) || cyc == abort)) req_cpu2cc = 1'b0;
      if (!req_cpu2cc && !req_cc2mem) tail++;
    end
    chk("op_done", 32'(tail >= 3), 32'd1);
  endtask

  task automatic rd_miss(input logic [31:0] a, input string tag);
    logic [31:0] rd; int lat, nack;
    cpu_op(1'b0, a, '0, 0, 0, rd, lat, nack);
    chk({tag, "_beats"}, 32'(beats), 32'd4);
    chk({tag, "_data"}, rd, 32'h100 + {30'h0, a[3:2]});
  endtask

  task automatic rd_hit(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd; int lat, nack;
    cpu_op(1'b0, a, '0, 0, 0, rd, lat, nack);
    chk({tag, "_beats"}, 32'(beats), 32'd0);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, nack;
    rst = 1'b0; req_cpu2cc = 1'b0; rdwr_cpu2cc = 1'b0; adr_cpu2cc = '0; dat_cpu2cc = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, ack_cc2cpu}, 32'd0);
    chk("rst_req_mem", {31'h0, req_cc2mem}, 32'd0);
    chk("rst_rdwr_mem", {31'h0, rdwr_cc2mem}, 32'd0);
    chk("rst_adr_mem", adr_cc2mem, 32'd0);
    chk("rst_dat_mem", dat_cc2mem, 32'd0);
    chk("rst_dat_cpu", dat_cc2cpu, 32'd0);
    rst = 1'b1;

    // Cold miss: index 16, word 2
    cpu_op(1'b0, 32'hFF07BD08, '0, 0, 0, rd, lat, nack);
    chk("cold_beats", 32'(beats), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cold_adr", b_adr[i], 32'hFF07BD00 + {28'h0, ORD[2*i +: 2], 2'b00});
      chk("cold_rdwr", {31'h0, b_wr[i]}, 32'd0);
    end
    chk("cold_data", rd, 32'h102);
    chk("cold_lat", 32'(lat), 32'(MISS_LAT));
    chk("cold_nack", 32'(nack), 32'd1);

    // Hit with request held for 6 cycles and address scrambled after sampling
    cpu_op(1'b0, 32'hFF07BD00, '0, 6, 0, rd, lat, nack);
    chk("hold_data", rd, 32'h100);
    chk("hold_lat", 32'(lat), 32'd2);
    chk("hold_nack", 32'(nack), 32'd1);
    chk("hold_beats", 32'(beats), 32'd0);

    // Fill the remaining ways of set 16, then overflow into round-robin
    rd_miss(32'h00000D00, "fill1");
    rd_miss(32'h11110D00, "fill2");
    rd_miss(32'h22220D00, "fill3");
    rd_miss(32'h33330D00, "evict0");
    rd_miss(32'hFF07BD08, "reread_first");
    rd_hit(32'h11110D00, 32'h100, "hit_w2");
    rd_hit(32'h33330D04, 32'h101, "hit_w0");

    // Write hit: line first brought in (evicts way 2), then written through
    rd_miss(32'hA5552D08, "wpre");
    cpu_op(1'b1, 32'hA5552D08, 32'hAA8AAAA4, 0, 0, rd, lat, nack);
    chk("wr_beats", 32'(beats), 32'd1);
    chk("wr_rdwr", {31'h0, b_wr[0]}, 32'd1);
    chk("wr_adr", b_adr[0], 32'hA5552D08);
    chk("wr_dat", b_dat[0], 32'hAA8AAAA4);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_nack", 32'(nack), 32'd1);
    chk("dat_hold", dat_cc2cpu, 32'h102);
    rd_hit(32'hA5552D08, 32'hAA8AAAA4, "wr_hit");

    // Write miss does not allocate
    cpu_op(1'b1, 32'h44440D04, 32'h12345678, 0, 0, rd, lat, nack);
    chk("wm_beats", 32'(beats), 32'd1);
    chk("wm_adr", b_adr[0], 32'h44440D04);
    rd_miss(32'h44440D04, "wm_read");

    // Request dropped during refill: no ack, line still installed
    cpu_op(1'b0, 32'h55550E00, '0, 0, 2, rd, lat, nack);
    chk("abort_nack", 32'(nack), 32'd0);
    chk("abort_beats", 32'(beats), 32'd4);
    rd_hit(32'h55550E04, 32'h101, "abort_hit");

    // Reset after second refill beat
    beats = 0;
    @(negedge clk);
    adr_cpu2cc = 32'h66660E08; rdwr_cpu2cc = 1'b0; req_cpu2cc = 1'b1;
    for (int i = 0; i < 60 && beats < 2; i++) @(negedge clk);
    chk("rst_wait", 32'(beats >= 2), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, req_cc2mem}, 32'd0);
    chk("mid_rst_ack", {31'h0, ack_cc2cpu}, 32'd0);
    chk("mid_rst_adr", adr_cc2mem, 32'd0);
    req_cpu2cc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cpu_op(1'b0, 32'h66660E08, '0, 0, 0, rd, lat, nack);
    chk("post_rst_beats", 32'(beats), 32'd4);
    chk("post_rst_data", rd, 32'h102);
    chk("post_rst_adr3", b_adr[3], 32'h66660E00 + {28'h0, ORD[7:6], 2'b00});
    rd_miss(32'h55550E04, "post_rst_cleared");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/setassoc_cache_ctrl.md
SETASSOC_CACHE_CTRL -- requirements
Module: setassoc_cache_ctrl
Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32, CPU/memory byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; byte offset = log2(DATA_WIDTH/8).
REQ-003 SHALL have parameter WAYS, default 4, associativity; power of two >= 1 (1 = direct mapped).
REQ-004 SHALL have parameter SETS, default 64, sets; power of two >= 2.
REQ-005 SHALL have parameter WORDS, default 4, words per line; power of two >= 2.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports req_cpu2cc input 1, adr_cpu2cc input ADR_WIDTH, dat_cpu2cc input DATA_WIDTH, rdwr_cpu2cc input 1 (1 = write): CPU request.
REQ-009 SHALL have ports ack_cc2cpu output 1 (one-cycle pulse), dat_cc2cpu output DATA_WIDTH: CPU response.
REQ-010 SHALL have ports req_cc2mem output 1, adr_cc2mem output ADR_WIDTH (word-aligned), dat_cc2mem output DATA_WIDTH, rdwr_cc2mem output 1 (1 = write): memory request.
REQ-011 SHALL have ports ack_mem2cc input 1 (one pulse per word), dat_mem2cc input DATA_WIDTH: memory response.
Function
REQ-012 SHALL split address as tag | index (log2 SETS) | word (log2 WORDS) | byte offset; tag = remainder.
REQ-013 SHALL implement FSM IDLE -> LOOKUP -> {RESP | REFILL | MEMWR} -> RESP -> HOLD -> IDLE.
REQ-014 IDLE SHALL latch adr/dat/rdwr when req_cpu2cc=1; input changes after latching are ignored until IDLE is re-entered.
REQ-015 LOOKUP SHALL compare the latched tag against all valid ways of the indexed set in one cycle.
REQ-016 Read hit SHALL drive dat_cc2cpu with the hit word and pulse ack_cc2cpu exactly 2 cycles after the request is sampled; no memory request.
REQ-017 Read miss SHALL select a victim: lowest-index invalid way, else way = per-set round-robin pointer, which then increments modulo WAYS.
REQ-018 REFILL SHALL hold req_cc2mem=1, rdwr_cc2mem=0; adr_cc2mem = line base + beat*DATA_WIDTH/8; beat counter advances on each ack_mem2cc, and each word is written into the victim way.
REQ-019 REFILL SHALL drop req_cc2mem the cycle after the WORDS-th ack, set the victim valid with new tag, then pulse ack_cc2cpu with the requested word.
REQ-020 Writes SHALL be write-through, no-write-allocate: hit updates the cached word in LOOKUP; hit or miss then enters MEMWR.
REQ-021 MEMWR SHALL hold req_cc2mem=1, rdwr_cc2mem=1, adr_cc2mem=latched word address, dat_cc2mem=latched data until ack_mem2cc, then pulse ack_cc2cpu.
REQ-022 HOLD SHALL wait for req_cpu2cc=0 before returning to IDLE, so a request held high after its ack is not serviced twice.
REQ-023 ack_mem2cc outside REFILL/MEMWR SHALL be ignored.
REQ-024 If req_cpu2cc falls during REFILL/MEMWR, the transfer SHALL complete and install/write normally, and ack_cc2cpu SHALL be suppressed.
REQ-025 dat_cc2cpu SHALL hold its last value when ack_cc2cpu=0.
Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, clear all valid bits, round-robin pointers and beat counter, and drive every output to 0.
REQ-027 Reset mid-REFILL SHALL drop req_cc2mem immediately and discard the partial line; that line SHALL miss afterwards.
Configuration
REQ-028 Macro CACHE_EARLY_RESTART_EN defined: refill SHALL start at the requested word, wrap modulo WORDS, and pulse ack_cc2cpu the cycle after the first beat with that data; refill continues in the background; the next request waits in HOLD/IDLE until refill ends.
REQ-029 Macro undefined: refill SHALL start at word 0, ascending, with acknowledgement only per REQ-019.
Verification (WAYS=4, SETS=64, WORDS=4)
REQ-030 Cold read 0xFF07BD08 (index 16, word 2), memory returns 0x100+beat -> adr_cc2mem 0xFF07BD00/04/08/0C, ack_cc2cpu with 0x102, line installed in way 0.
REQ-031 Then read 0xFF07BD00 -> ack_cc2cpu 2 cycles after request with 0x100, req_cc2mem stays 0; req held high 3 cycles -> exactly one ack.
REQ-032 Five read misses with distinct tags on index 16 -> ways 0-3 filled, fifth replaces way 0; re-read of first tag misses.
REQ-033 Write hit 0xA5552D08 data 0xAA8AAAA4 -> memory write with rdwr_cc2mem=1, ack after ack_mem2cc; read of 0xA5552D08 then hits with 0xAA8AAAA4.
REQ-034 CACHE_EARLY_RESTART_EN, miss at 0xA5552D0C -> beats 0x...0C, 0x...00, 0x...04, 0x...08; ack_cc2cpu one cycle after first beat.
REQ-035 rst=0 after second refill beat -> req_cc2mem low the same cycle; after release, same address misses and refills fully.
